// File: rtl/tx_baseband_pkg.sv
// Shared types, fixed-point constants and the output saturation helper for the
// transmit baseband path.
package tx_baseband_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } state_t;

  localparam int SAMPLE_W    = 16;
  localparam int FRAC_W      = 15;
  localparam int ROUND_CONST = 16384;
  localparam int SAT_MAX     = 32767;
  localparam int SAT_MIN     = -32768;

  // Clamp the rounded, rescaled mixer result into the signed Q1.15 range.
  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [17:0] x);
    logic signed [17:0] hi_v;
    logic signed [17:0] lo_v;
    hi_v = 18'(SAT_MAX);
    lo_v = 18'(SAT_MIN);
    if (x > hi_v) begin
      return 16'(SAT_MAX);
    end else if (x < lo_v) begin
      return 16'(SAT_MIN);
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tx_baseband_transmitter_upmix.sv
// Mixer back half: registered products, then subtract, round, rescale and
// saturate into the registered DAC sample.
module tx_upmix_stage
  import tx_baseband_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] i_sample,
  input  logic signed [SAMPLE_W-1:0] q_sample,
  input  logic signed [SAMPLE_W-1:0] cos_sample,
  input  logic signed [SAMPLE_W-1:0] sin_sample,
  output logic signed [SAMPLE_W-1:0] data_out,
  output logic                       data_out_valid
);

  logic signed [31:0] p1_r;
  logic signed [31:0] p2_r;
  logic               s1_valid_r;
  logic signed [32:0] diff_s;
  logic signed [32:0] rnd_s;
  logic signed [17:0] shifted_s;

  // Stage S1: full-precision products of the aligned sample and carrier.
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_r       <= 32'sd0;
      p2_r       <= 32'sd0;
      s1_valid_r <= 1'b0;
    end else begin
      p1_r       <= 32'(i_sample) * 32'(cos_sample);
      p2_r       <= 32'(q_sample) * 32'(sin_sample);
      s1_valid_r <= sample_valid;
    end
  end

  // Difference is kept at 33 bits so the extreme corner cannot wrap before rounding.
  assign diff_s    = 33'(p1_r) - 33'(p2_r);
  assign rnd_s     = diff_s + 33'(ROUND_CONST);
  assign shifted_s = rnd_s[32:FRAC_W];

  // Stage S2: saturated output; the sample is forced to zero whenever it is not valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out       <= 16'sd0;
      data_out_valid <= 1'b0;
    end else if (s1_valid_r) begin
      data_out       <= saturate(shifted_s);
      data_out_valid <= 1'b1;
    end else begin
      data_out       <= 16'sd0;
      data_out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_baseband_transmitter.sv
// Block-to-stream transmitter: 2-slot ping-pong buffer, serializer FSM,
// carrier alignment stage S0 and the up-mixer feeding the DAC.
module tx_baseband_transmitter
  import tx_baseband_pkg::*;
#(
  parameter int NUMBER_OF_PATH = 4,
  parameter int UNDERFLOW_W    = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [SAMPLE_W*NUMBER_OF_PATH-1:0]   s_data_i,
  input  logic [SAMPLE_W*NUMBER_OF_PATH-1:0]   s_data_q,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic signed [SAMPLE_W-1:0]           carrier_cos,
  input  logic signed [SAMPLE_W-1:0]           carrier_sin,
  output logic signed [SAMPLE_W-1:0]           data_out,
  output logic                                 data_out_valid,
  output logic [UNDERFLOW_W-1:0]               underflow_count
);

  localparam int IDX_W = $clog2(NUMBER_OF_PATH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUMBER_OF_PATH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  logic [SAMPLE_W*NUMBER_OF_PATH-1:0] slot_i_r [2];
  logic [SAMPLE_W*NUMBER_OF_PATH-1:0] slot_q_r [2];
  logic                               wr_ptr_r;
  logic                               rd_ptr_r;
  logic [1:0]                         count_r;
  logic                               wr_en_s;
  logic                               release_s;

  state_t                             state_r;
  state_t                             state_nx_s;
  logic [IDX_W-1:0]                   idx_r;
  logic [IDX_W-1:0]                   idx_nx_s;
  logic                               present_s;
  logic                               starve_s;
  logic [UNDERFLOW_W-1:0]             underflow_r;

  logic signed [SAMPLE_W-1:0]         cur_i_s;
  logic signed [SAMPLE_W-1:0]         cur_q_s;
  logic signed [SAMPLE_W-1:0]         s0_i_r;
  logic signed [SAMPLE_W-1:0]         s0_q_r;
  logic signed [SAMPLE_W-1:0]         s0_cos_r;
  logic signed [SAMPLE_W-1:0]         s0_sin_r;
  logic                               s0_valid_r;

  assign s_ready         = (count_r < 2'd2);
  assign wr_en_s         = s_valid && s_ready;
  assign release_s       = (state_r == RUN) && (idx_r == LAST_IDX);
  assign underflow_count = underflow_r;

  // Ping-pong buffer: a write and a release on the same edge leave the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_i_r[0] <= '0;
      slot_i_r[1] <= '0;
      slot_q_r[0] <= '0;
      slot_q_r[1] <= '0;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
    end else begin
      if (wr_en_s) begin
        slot_i_r[wr_ptr_r] <= s_data_i;
        slot_q_r[wr_ptr_r] <= s_data_q;
        wr_ptr_r           <= ~wr_ptr_r;
      end
      if (release_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({wr_en_s, release_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state and path index register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
    end
  end

  // Next state; at the last path only a block already sitting in the other slot continues the run.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (enable && (count_r != 2'd0)) begin
          state_nx_s = RUN;
          idx_nx_s   = IDX_ZERO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          idx_nx_s = IDX_ZERO;
          if (enable && (count_r == 2'd2)) begin
            state_nx_s = RUN;
          end else if (enable) begin
            state_nx_s = STARVED;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          idx_nx_s = idx_r + IDX_ONE;
        end
      end
      STARVED: begin
        if (!enable) begin
          state_nx_s = IDLE;
        end else if (count_r != 2'd0) begin
          state_nx_s = RUN;
          idx_nx_s   = IDX_ZERO;
        end else begin
          state_nx_s = STARVED;
        end
      end
      default: begin
        state_nx_s = IDLE;
        idx_nx_s   = IDX_ZERO;
      end
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    present_s = 1'b0;
    starve_s  = 1'b0;
    case (state_r)
      RUN:     present_s = 1'b1;
      STARVED: starve_s  = 1'b1;
      default: begin
        present_s = 1'b0;
        starve_s  = 1'b0;
      end
    endcase
  end

  // Saturating count of cycles spent waiting for data while enabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_r <= '0;
    end else if (starve_s && (underflow_r != {UNDERFLOW_W{1'b1}})) begin
      underflow_r <= underflow_r + UNDERFLOW_W'(1);
    end
  end

  assign cur_i_s = slot_i_r[rd_ptr_r][SAMPLE_W*int'(idx_r) +: SAMPLE_W];
  assign cur_q_s = slot_q_r[rd_ptr_r][SAMPLE_W*int'(idx_r) +: SAMPLE_W];

  // Stage S0: capture the presented path together with the carrier on the bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_i_r     <= 16'sd0;
      s0_q_r     <= 16'sd0;
      s0_cos_r   <= 16'sd0;
      s0_sin_r   <= 16'sd0;
      s0_valid_r <= 1'b0;
    end else begin
      s0_valid_r <= present_s;
      if (present_s) begin
        s0_i_r   <= cur_i_s;
        s0_q_r   <= cur_q_s;
        s0_cos_r <= carrier_cos;
        s0_sin_r <= carrier_sin;
      end
    end
  end

  tx_upmix_stage u_upmix (
    .clock          (clock),
    .reset          (reset),
    .sample_valid   (s0_valid_r),
    .i_sample       (s0_i_r),
    .q_sample       (s0_q_r),
    .cos_sample     (s0_cos_r),
    .sin_sample     (s0_sin_r),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

endmodule

// File: doc/tx_baseband_transmitter.md
Name: tx_baseband_transmitter

Overview:
Transmit-side counterpart of the receive baseband path. It accepts blocks of NUMBER_OF_PATH parallel complex baseband samples over a valid/ready handshake and buffers them in a 2-slot ping-pong buffer. It serializes each block to one sample per clock, path 0 first. Each sample is up-mixed with an externally supplied carrier from a DDS, out = I*cos - Q*sin, then rounded and saturated to one 16-bit real stream for the DAC.

Parameters:
NUMBER_OF_PATH, 4, samples per input block; legal range 2..16
UNDERFLOW_W, 16, width of the saturating underflow counter

Ports:
clock  input  1  single clock for the whole block
reset  input  1  synchronous, active-high reset
enable  input  1  allows serialization; input acceptance is independent of it
s_data_i  input  16*NUMBER_OF_PATH  I samples, signed Q1.15; path k in bits [16k+15:16k]
s_data_q  input  16*NUMBER_OF_PATH  Q samples, same packing
s_valid  input  1  block valid
s_ready  output  1  block accepted on an edge where s_valid && s_ready
carrier_cos  input  16  signed Q1.15 carrier cosine, one sample per clock
carrier_sin  input  16  signed Q1.15 carrier sine
data_out  output  16  signed Q1.15 up-mixed sample
data_out_valid  output  1  data_out is valid this cycle
underflow_count  output  UNDERFLOW_W  starvation cycles; saturates at all-ones

Behaviour:
- Reset (synchronous, active-high; applies on the edge including mid-block): both slots empty, FSM to IDLE, path index 0, pipeline valids 0, data_out=0, data_out_valid=0, underflow_count=0. s_ready is 1 on the first cycle after reset deasserts.
- Buffer: 2 slots with a fill count 0..2. s_ready = (count < 2), combinational from registered state. There is no same-edge bypass when full. A write and a slot release on the same edge are both honoured: count is unchanged and the slot order is preserved. Blocks are played strictly in acceptance order.
- FSM states:
  - IDLE: no output. If enable && count>0, load the oldest slot and go to RUN with idx=0.
  - RUN: present path idx of the current slot to the mixer each cycle.
    - At idx==N-1 the slot is released.
    - If enable && another block is buffered (counting one written on this same edge only if it was already in a slot before the edge; else wait), go to RUN with idx=0 on the next slot. Back-to-back blocks produce no gap.
    - Else if enable, go to STARVED.
    - Else go to IDLE.
  - Deasserting enable mid-block does not stop the current block; it completes.
  - STARVED: no output; underflow_count increments every cycle spent here, saturating. Go to RUN when count>0 and enable; go to IDLE when enable is low. The IDLE->RUN transition never counts as underflow.
- Mixer pipeline, stage S0 (on the edge the serializer presents path idx): register I, Q, carrier_cos and carrier_sin together, with valid.
- Mixer pipeline, stage S1: register the signed 32-bit products p1=I*cos and p2=Q*sin.
- Mixer pipeline, stage S2: d = p1 - p2 at 33 bits; add 2^14; arithmetic shift right by 15; saturate to [-32768, 32767]; register into data_out, with data_out_valid.
- Latency: block accepted at edge k, buffer previously empty, FSM in IDLE with enable high:
  - FSM enters RUN at edge k+1.
  - Path 0 captured in S0 at edge k+2, using carrier on the bus before edge k+2.
  - data_out valid after edge k+4.
  - Each subsequent path follows one cycle later.
- When data_out_valid=0, data_out=0.

Decomposition:
- Package tx_baseband_pkg:
  - state enum {IDLE, RUN, STARVED}
  - SAMPLE_W=16, FRAC_W=15, ROUND_CONST=2^14, SAT_MAX=32767, SAT_MIN=-32768
  - a saturate function
- Sub-module tx_upmix_stage: stages S1-S2 (multiply, subtract, round, saturate) with a valid pipeline. The top level holds the buffer, FSM, serializer and S0.

Test Plan:
- Single block: N=4, I={1000,2000,3000,4000}, Q=0, cos=32767, sin=0, enable=1 -> data_out {1000,2000,3000,4000}, data_out_valid high for exactly 4 cycles starting 4 cycles after acceptance; underflow_count then increments once per cycle.
- Saturation: I=Q=-32768, cos=-32768, sin=32767 -> data_out=32767. I=32767, Q=-32768, cos=-32768, sin=-32768 -> data_out=-32768.
- Streaming: s_valid held high for 10 blocks, enable=1 -> 40 consecutive valid samples with no gap, order preserved, s_ready never blocks steady state, underflow_count=0 until the stream ends.
- Backpressure: enable=0, offer 3 blocks -> s_ready drops after 2 accepted. Raise enable -> block 1 then block 2 play back-to-back; the third is accepted once the first slot frees.
- Enable drop mid-block: deassert enable at idx=1 -> all 4 samples of that block still emitted, then IDLE; underflow_count unchanged.
- Reset mid-block: assert reset at idx=2 with both slots full -> next cycle data_out_valid=0, data_out=0, s_ready=1, underflow_count=0; no stale samples after reset releases.
